// File: rtl/dm_port_arbiter_pkg.sv
// rtl/dm_port_arbiter_pkg.sv - DM op codes, arbiter states and access-check helper
package dm_port_arbiter_pkg;

    localparam logic [2:0] DM_OP_BYTE      = 3'b000;
    localparam logic [2:0] DM_OP_HALF_WORD = 3'b001;
    localparam logic [2:0] DM_OP_WORD      = 3'b010;

    localparam int DM_RAM_SIZE = 3072;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Any op code the DM does not recognise behaves as a word access.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lsb);
        case (op)
            DM_OP_BYTE:      return 1'b0;
            DM_OP_HALF_WORD: return lsb[0];
            default:         return lsb != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_pick2.sv
// rtl/dm_port_arbiter_rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       valid
);

    // On a tie the master that was not granted last time wins.
    assign grant[0] = req[0] & (~req[1] | last);
    assign grant[1] = req[1] & (~req[0] | ~last);
    assign valid    = |req;

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - round-robin sharing of the data memory port between two masters
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DM_WORDS = DM_RAM_SIZE
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [2:0]        i_m0_dmOp,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [2:0]        i_m1_dmOp,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m0_stall,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [DATA_W-1:0] o_dm_wdata,
    output logic              o_dm_we,
    output logic [2:0]        o_dm_op,
    input  logic [DATA_W-1:0] i_dm_rdata
);

    localparam logic [ADDR_W-3:0] DM_WORDS_LIM = (ADDR_W-2)'(DM_WORDS);

    arb_state_t        state;
    logic              last_m1;
    logic              sel_m1;
    logic              we_q;
    logic              err_q;
    logic [1:0]        grant;
    logic              pick_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_op;
    logic              req_err;
    logic [DATA_W-1:0] resp_data;

    rr_pick2 u_pick (
        .req   ({i_m1_req, i_m0_req}),
        .last  (last_m1),
        .grant (grant),
        .valid (pick_valid)
    );

    // grant is one-hot, so an AND-OR mux selects the winner's request fields.
    always_comb begin
        req_we    = (grant[0] & i_m0_we) | (grant[1] & i_m1_we);
        req_addr  = ({ADDR_W{grant[0]}} & i_m0_addr)  | ({ADDR_W{grant[1]}} & i_m1_addr);
        req_wdata = ({DATA_W{grant[0]}} & i_m0_wdata) | ({DATA_W{grant[1]}} & i_m1_wdata);
        req_op    = ({3{grant[0]}} & i_m0_dmOp)       | ({3{grant[1]}} & i_m1_dmOp);
        req_err   = op_misaligned(req_op, req_addr[1:0])
                  | (req_addr[ADDR_W-1:2] >= DM_WORDS_LIM);
        resp_data = (err_q | we_q) ? '0 : i_dm_rdata;
    end

    assign o_m0_stall = i_m0_req & ~o_m0_ack;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ARB_IDLE;
            last_m1    <= 1'b1;
            sel_m1     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            o_dm_addr  <= '0;
            o_dm_wdata <= '0;
            o_dm_we    <= 1'b0;
            o_dm_op    <= '0;
            o_m0_ack   <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m0_rdata <= '0;
            o_m1_ack   <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m1_rdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    o_dm_we <= 1'b0;
                    if (pick_valid) begin
                        sel_m1     <= grant[1];
                        we_q       <= req_we;
                        err_q      <= req_err;
                        o_dm_addr  <= req_addr;
                        o_dm_wdata <= req_wdata;
                        o_dm_op    <= req_op;
                        o_dm_we    <= req_we & ~req_err;
                        state      <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    o_dm_we <= 1'b0;
                    if (sel_m1) begin
                        o_m1_ack   <= 1'b1;
                        o_m1_err   <= err_q;
                        o_m1_rdata <= resp_data;
                    end else begin
                        o_m0_ack   <= 1'b1;
                        o_m0_err   <= err_q;
                        o_m0_rdata <= resp_data;
                    end
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    o_m0_ack   <= 1'b0;
                    o_m0_err   <= 1'b0;
                    o_m0_rdata <= '0;
                    o_m1_ack   <= 1'b0;
                    o_m1_err   <= 1'b0;
                    o_m1_rdata <= '0;
                    last_m1    <= sel_m1;
                    state      <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    localparam int NW = 3072;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_op, m1_op;
    logic        m0_ack, m0_err, m1_ack, m1_err, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;
    logic [2:0]  dm_op;

    always #5 clk = ~clk;

    dm_port_arbiter #(.DATA_W(32), .ADDR_W(32), .DM_WORDS(NW)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_dmOp(m0_op), .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_dmOp(m1_op), .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
        .o_m0_stall(m0_stall), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata), .o_dm_we(dm_we),
        .o_dm_op(dm_op), .i_dm_rdata(dm_rdata)
    );

    // Data memory stand-in: combinational read, word write on the clock edge.
    logic [31:0] dm_mem [0:NW-1];
    int we_cnt = 0;
    always_comb begin
        dm_rdata = 32'h0;
        if (dm_addr[31:2] < 30'd3072) dm_rdata = dm_mem[dm_addr[13:2]];
    end
    always @(posedge clk) begin
        if (dm_we && dm_addr[31:2] < 30'd3072) dm_mem[dm_addr[13:2]] <= dm_wdata;
        if (dm_we) we_cnt <= we_cnt + 1;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        last_g;
    logic [31:0] shadow [0:15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] op);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd; m0_op = op;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; m1_op = op;
        end
    endtask

    function automatic logic model_err(input logic [2:0] op, input logic [31:0] a);
        logic mis;
        if (op == DM_OP_HALF_WORD)  mis = a[0];
        else if (op == DM_OP_BYTE)  mis = 1'b0;
        else                        mis = (a[1:0] != 2'b00);
        return mis || (a[31:2] >= 30'd3072);
    endfunction

    // Random traffic only touches words 0..15, mirrored in shadow[].
    task automatic model_serve(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] op, output logic err, output logic [31:0] rd);
        err = model_err(op, a);
        rd  = 32'h0;
        if (!err) begin
            if (we) shadow[a[5:2]] = wd;
            else    rd = shadow[a[5:2]];
        end
    endtask

    task automatic do_access(input int m, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] op,
                             input logic e_err, input logic [31:0] e_rd, input string tag);
        int   lat;
        int   w0;
        logic got;
        drive(m, 1'b1, we, a, wd, op);
        w0  = we_cnt;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            got = (m == 0) ? m0_ack : m1_ack;
        end
        chk({tag, "_lat"}, lat, 2);
        if (got) begin
            chk({tag, "_err"},   (m == 0) ? m0_err : m1_err, e_err);
            chk({tag, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, e_rd);
            if (m == 0) chk({tag, "_stall"}, m0_stall, 0);
        end
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, DM_OP_WORD);
        tick();
        chk({tag, "_we"}, we_cnt - w0, (we && !e_err) ? 1 : 0);
        last_g = (m != 0);
    endtask

    function automatic logic [2:0] pick_op(input int i);
        case (i)
            0:       return DM_OP_WORD;
            1:       return DM_OP_HALF_WORD;
            2:       return DM_OP_BYTE;
            default: return 3'b111;
        endcase
    endfunction

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          bad, k, t, n, stall_bad, w0, exp_we;
        int          ord [2];
        logic        we_r [2];
        logic [31:0] addr_r [2];
        logic [31:0] wd_r [2];
        logic [2:0]  op_r [2];
        logic        e_err [2];
        logic [31:0] e_rd [2];
        logic [1:0]  pat;
        logic        acked;

        tbl[0]  = '{0, 1'b1, 32'h10,   32'hDEADBEEF, DM_OP_WORD,      1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 32'h10,   32'h0,        DM_OP_WORD,      1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1, 1'b1, 32'h3,    32'hAAAA5555, DM_OP_HALF_WORD, 1'b1, 32'h0};
        tbl[3]  = '{1, 1'b1, 32'h2,    32'h55556666, DM_OP_WORD,      1'b1, 32'h0};
        tbl[4]  = '{1, 1'b1, 32'h3000, 32'h77778888, DM_OP_WORD,      1'b1, 32'h0};
        tbl[5]  = '{1, 1'b1, 32'h2FFC, 32'h12345678, DM_OP_WORD,      1'b0, 32'h0};
        tbl[6]  = '{1, 1'b0, 32'h2FFC, 32'h0,        DM_OP_WORD,      1'b0, 32'h12345678};
        tbl[7]  = '{0, 1'b0, 32'h13,   32'h0,        DM_OP_BYTE,      1'b0, 32'hDEADBEEF};
        tbl[8]  = '{0, 1'b0, 32'h11,   32'h0,        DM_OP_HALF_WORD, 1'b1, 32'h0};
        tbl[9]  = '{1, 1'b0, 32'h12,   32'h0,        3'b111,          1'b1, 32'h0};
        tbl[10] = '{1, 1'b0, 32'h10,   32'h0,        3'b111,          1'b0, 32'hDEADBEEF};
        tbl[11] = '{0, 1'b0, 32'h3000, 32'h0,        DM_OP_BYTE,      1'b1, 32'h0};

        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, DM_OP_WORD);
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0, DM_OP_WORD);
        bad = 0;
        repeat (5) begin
            tick();
            if (m0_ack || m1_ack || dm_we) bad++;
        end
        chk("reset_quiet", bad, 0);
        chk("reset_dm_addr", dm_addr, 0);
        chk("reset_stall", m0_stall, 1);

        // Both masters held requesting from reset release: strict alternation, m0 first.
        #2 rst_n = 1'b1;
        k = 0; t = 0; stall_bad = 0;
        while (k < 4 && t < 30) begin
            tick();
            t++;
            if (m0_stall !== !m0_ack) stall_bad++;
            if (m0_ack || m1_ack) begin
                chk("alt_order", m1_ack ? 1 : 0, k % 2);
                chk("alt_onehot", m0_ack & m1_ack, 0);
                chk("alt_time", t, 2 + 3 * k);
                k++;
                if (k == 4) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        chk("alt_count", k, 4);
        chk("alt_stall", stall_bad, 0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        last_g = 1'b1;

        for (int i = 0; i < 12; i++)
            do_access(tbl[i].m, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].op,
                      tbl[i].exp_err, tbl[i].exp_rdata, $sformatf("vec%0d", i));

        // Reset during ACCESS of a store kills the write and the ack.
        do_access(0, 1'b1, 32'h40, 32'h11111111, DM_OP_WORD, 1'b0, 32'h0, "abort_pre");
        drive(0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, DM_OP_WORD);
        w0 = we_cnt;
        tick();
        chk("abort_we_on", dm_we, 1);
        chk("abort_addr", dm_addr, 32'h40);
        #1 rst_n = 1'b0;
        #1 chk("abort_we_off", dm_we, 0);
        m0_req = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (m0_ack || m1_ack) bad++;
        end
        chk("abort_no_ack", bad, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_no_write", we_cnt - w0, 0);
        last_g = 1'b1;
        do_access(0, 1'b0, 32'h40, 32'h0, DM_OP_WORD, 1'b0, 32'h11111111, "abort_post");

        // Request held through ack with a new address is a second access.
        do_access(0, 1'b1, 32'h20, 32'h0BADCAFE, DM_OP_WORD, 1'b0, 32'h0, "held_pre");
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, DM_OP_WORD);
        t = 0;
        while (!m0_ack && t < 20) begin
            tick();
            t++;
        end
        chk("held_first_lat", t, 2);
        chk("held_first_rd", m0_rdata, 32'hDEADBEEF);
        m0_addr = 32'h20;
        t = 0;
        do begin
            tick();
            t++;
        end while (!m0_ack && t < 20);
        chk("held_second_lat", t, 3);
        chk("held_second_rd", m0_rdata, 32'h0BADCAFE);
        m0_req = 1'b0;
        tick();
        last_g = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic        pe;
            logic [31:0] pr;
            logic [31:0] v;
            v = $urandom;
            model_serve(1'b1, 32'(i * 4), v, DM_OP_WORD, pe, pr);
            do_access(i % 2, 1'b1, 32'(i * 4), v, DM_OP_WORD, pe, pr, "preload");
        end

        for (int r = 0; r < 150; r++) begin
            pat = 2'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                int sel;
                we_r[m] = 1'($urandom_range(0, 1));
                wd_r[m] = $urandom;
                op_r[m] = pick_op($urandom_range(0, 3));
                sel     = $urandom_range(0, 9);
                if (sel < 7)       addr_r[m] = 32'($urandom_range(0, 63));
                else if (sel < 9)  addr_r[m] = 32'($urandom_range(0, 15) * 4);
                else               addr_r[m] = 32'h3000 + 32'($urandom_range(0, 255) * 4);
            end
            if (pat == 2'b11) begin
                ord[0] = last_g ? 0 : 1;
                ord[1] = 1 - ord[0];
                n = 2;
            end else begin
                ord[0] = pat[1] ? 1 : 0;
                n = 1;
            end
            exp_we = 0;
            for (int j = 0; j < n; j++) begin
                model_serve(we_r[ord[j]], addr_r[ord[j]], wd_r[ord[j]], op_r[ord[j]],
                            e_err[ord[j]], e_rd[ord[j]]);
                if (we_r[ord[j]] && !e_err[ord[j]]) exp_we++;
            end
            last_g = (ord[n-1] != 0);
            for (int m = 0; m < 2; m++)
                drive(m, pat[m], we_r[m], addr_r[m], wd_r[m], op_r[m]);
            w0 = we_cnt;
            k = 0; t = 0; stall_bad = 0;
            while (k < n && t < 20) begin
                tick();
                t++;
                if (m0_stall !== (m0_req & !m0_ack)) stall_bad++;
                for (int m = 0; m < 2; m++) begin
                    acked = (m == 0) ? m0_ack : m1_ack;
                    if (acked) begin
                        chk("rnd_order", m, (k < n) ? ord[k] : -1);
                        chk("rnd_time", t, 2 + 3 * k);
                        chk("rnd_err", (m == 0) ? m0_err : m1_err, e_err[m]);
                        chk("rnd_rdata", (m == 0) ? m0_rdata : m1_rdata, e_rd[m]);
                        k++;
                        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, DM_OP_WORD);
                    end
                end
            end
            chk("rnd_done", k, n);
            chk("rnd_stall", stall_bad, 0);
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0, DM_OP_WORD);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0, DM_OP_WORD);
            tick();
            chk("rnd_we", we_cnt - w0, exp_we);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
